// File: rtl/mha_pkg.sv
// Shared types and default sizing for the attention running-max/row-sum update controller.
package mha_pkg;

  localparam int D_W_DEF  = 8;
  localparam int TIL_DEF  = 16;
  localparam int NT_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_STAT = 3'd1,
    CALC      = 3'd2,
    EMIT      = 3'd3,
    FIN       = 3'd4
  } state_e;

endpackage

// File: rtl/o_upd_ctrl_if.sv
// Handshake/data bundle between the update controller, the stat producer, the coefficient
// datapath and the output accumulator. slave = controller view, master = environment view.
interface o_upd_ctrl_if
  import mha_pkg::*;
#(
  parameter int D_W  = D_W_DEF,
  parameter int TIL  = TIL_DEF,
  parameter int NT_W = NT_W_DEF
);
  logic                       I_START;
  logic [NT_W-1:0]            I_NUM_TILE;
  logic                       I_STAT_VLD;
  logic                       O_STAT_RDY;
  logic [TIL-1:0][2*D_W-1:0]  I_LI_NEW;
  logic [TIL-1:0][D_W-1:0]    I_MI_NEW;
  logic                       O_UPD_VLD;
  logic [TIL-1:0][2*D_W-1:0]  O_LI_OLD;
  logic [TIL-1:0][D_W-1:0]    O_MI_OLD;
  logic [TIL-1:0][2*D_W-1:0]  O_LI_NEW;
  logic [TIL-1:0][D_W-1:0]    O_MI_NEW;
  logic                       I_UPD_DONE;
  logic [TIL-1:0][D_W-1:0]    I_COEF;
  logic                       O_COEF_VLD;
  logic                       I_COEF_RDY;
  logic [TIL-1:0][D_W-1:0]    O_COEF;
  logic                       O_FIRST;
  logic                       O_BUSY;
  logic                       O_DONE;
  logic [NT_W-1:0]            O_TILE_IDX;

  modport slave (
    input  I_START, I_NUM_TILE, I_STAT_VLD, I_LI_NEW, I_MI_NEW,
    input  I_UPD_DONE, I_COEF, I_COEF_RDY,
    output O_STAT_RDY, O_UPD_VLD, O_LI_OLD, O_MI_OLD, O_LI_NEW, O_MI_NEW,
    output O_COEF_VLD, O_COEF, O_FIRST, O_BUSY, O_DONE, O_TILE_IDX
  );

  modport master (
    output I_START, I_NUM_TILE, I_STAT_VLD, I_LI_NEW, I_MI_NEW,
    output I_UPD_DONE, I_COEF, I_COEF_RDY,
    input  O_STAT_RDY, O_UPD_VLD, O_LI_OLD, O_MI_OLD, O_LI_NEW, O_MI_NEW,
    input  O_COEF_VLD, O_COEF, O_FIRST, O_BUSY, O_DONE, O_TILE_IDX
  );

endinterface

// File: rtl/o_upd_ctrl.sv
// Sequences one row-block pass: collects per-tile stats, hands old/new pairs to the coef datapath.
// Latency: coefficient valid one cycle after I_UPD_DONE; datapath time itself is unbounded.
// Backpressure: stat intake stalls until the previous coefficient is taken by the accumulator.
module o_upd_ctrl
  import mha_pkg::*;
#(
  parameter int D_W  = D_W_DEF,
  parameter int TIL  = TIL_DEF,
  parameter int NT_W = NT_W_DEF
) (
  input logic         I_CLK,
  input logic         I_RST_N,
  o_upd_ctrl_if.slave bus
);

  typedef logic [TIL-1:0][2*D_W-1:0] li_vec_t;
  typedef logic [TIL-1:0][D_W-1:0]   mi_vec_t;

  localparam logic [NT_W-1:0] IDX_ONE = NT_W'(1);

  state_e          state_q,    state_d;
  logic [NT_W-1:0] num_tile_q, num_tile_d;
  logic [NT_W-1:0] tile_idx_q, tile_idx_d;
  li_vec_t         li_new_q,   li_new_d;
  mi_vec_t         mi_new_q,   mi_new_d;
  li_vec_t         li_old_q,   li_old_d;
  mi_vec_t         mi_old_q,   mi_old_d;
  mi_vec_t         coef_q,     coef_d;
  logic            zdone_q,    zdone_d;
  logic            last_tile;

  assign last_tile = (tile_idx_q == (num_tile_q - IDX_ONE));

  always_comb begin
    state_d    = state_q;
    num_tile_d = num_tile_q;
    tile_idx_d = tile_idx_q;
    li_new_d   = li_new_q;
    mi_new_d   = mi_new_q;
    li_old_d   = li_old_q;
    mi_old_d   = mi_old_q;
    coef_d     = coef_q;
    zdone_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.I_START) begin
          num_tile_d = bus.I_NUM_TILE;
          tile_idx_d = '0;
          // An empty pass still owes the caller a completion pulse.
          if (bus.I_NUM_TILE == '0) begin
            zdone_d = 1'b1;
          end else begin
            state_d = WAIT_STAT;
          end
        end
      end

      WAIT_STAT: begin
        if (bus.I_STAT_VLD) begin
          li_new_d = bus.I_LI_NEW;
          mi_new_d = bus.I_MI_NEW;
          if (tile_idx_q == '0) begin
            // First tile has nothing to rescale against: it seeds the running stats.
            li_old_d = bus.I_LI_NEW;
            mi_old_d = bus.I_MI_NEW;
            if (last_tile) begin
              state_d = FIN;
            end else begin
              tile_idx_d = tile_idx_q + IDX_ONE;
            end
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (bus.I_UPD_DONE) begin
          coef_d  = bus.I_COEF;
          state_d = EMIT;
        end
      end

      EMIT: begin
        if (bus.I_COEF_RDY) begin
          li_old_d = li_new_q;
          mi_old_d = mi_new_q;
          if (last_tile) begin
            state_d = FIN;
          end else begin
            tile_idx_d = tile_idx_q + IDX_ONE;
            state_d    = WAIT_STAT;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q    <= IDLE;
      num_tile_q <= '0;
      tile_idx_q <= '0;
      li_new_q   <= '0;
      mi_new_q   <= '0;
      li_old_q   <= '0;
      mi_old_q   <= '0;
      coef_q     <= '0;
      zdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_tile_q <= num_tile_d;
      tile_idx_q <= tile_idx_d;
      li_new_q   <= li_new_d;
      mi_new_q   <= mi_new_d;
      li_old_q   <= li_old_d;
      mi_old_q   <= mi_old_d;
      coef_q     <= coef_d;
      zdone_q    <= zdone_d;
    end
  end

  // All strobes decode straight from the state register so reset clears them at once.
  assign bus.O_STAT_RDY = (state_q == WAIT_STAT);
  assign bus.O_FIRST    = (state_q == WAIT_STAT) && (tile_idx_q == '0);
  assign bus.O_UPD_VLD  = (state_q == CALC);
  assign bus.O_COEF_VLD = (state_q == EMIT);
  assign bus.O_BUSY     = (state_q != IDLE);
  assign bus.O_DONE     = zdone_q || (state_q == FIN);
  assign bus.O_TILE_IDX = tile_idx_q;
  assign bus.O_COEF     = coef_q;
  assign bus.O_LI_OLD   = li_old_q;
  assign bus.O_MI_OLD   = mi_old_q;
  assign bus.O_LI_NEW   = li_new_q;
  assign bus.O_MI_NEW   = mi_new_q;

endmodule

// File: tb/tb_o_upd_ctrl.sv
// Randomized pass-level bench for o_upd_ctrl with a transaction model and per-cycle compare.
module tb_o_upd_ctrl;
  import mha_pkg::*;

  localparam int D_W  = D_W_DEF;
  localparam int TIL  = TIL_DEF;
  localparam int NT_W = NT_W_DEF;

  typedef logic [TIL-1:0][2*D_W-1:0] li_t;
  typedef logic [TIL-1:0][D_W-1:0]   mi_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  o_upd_ctrl_if #(.D_W(D_W), .TIL(TIL), .NT_W(NT_W)) u_if ();

  o_upd_ctrl #(.D_W(D_W), .TIL(TIL), .NT_W(NT_W)) u_dut (
    .I_CLK   (clk),
    .I_RST_N (rst_n),
    .bus     (u_if.slave)
  );

  int total = 0;
  int bad   = 0;

  // Pass model state: what the spec says must happen for the pass in flight.
  li_t li_tab[16];
  mi_t mi_tab[16];
  int  pass_n    = -1;
  int  lat       = 1;
  int  stall_len = 0;
  int  stat_cnt, coef_cnt, done_cnt, vld_cyc, first_cnt, emit_cyc;
  mi_t coef_exp;
  mi_t last_mi_old;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic li_t rnd_li();
    li_t v;
    for (int e = 0; e < TIL; e++) v[e] = (2*D_W)'($urandom);
    return v;
  endfunction

  function automatic mi_t rnd_mi();
    mi_t v;
    for (int e = 0; e < TIL; e++) v[e] = D_W'($urandom);
    return v;
  endfunction

  // Compare process: one look per cycle at the negative edge.
  initial begin : compare
    logic done_prev;
    int   k;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (u_if.I_STAT_VLD && u_if.O_STAT_RDY) begin
          chk("first_flag", u_if.O_FIRST, stat_cnt == 0);
          chk("stat_idx", u_if.O_TILE_IDX, stat_cnt);
          if (u_if.O_FIRST) first_cnt++;
          stat_cnt++;
        end
        if (done_prev) chk("coef_latency", {u_if.O_COEF_VLD, u_if.O_UPD_VLD}, 2'b10);
        done_prev = u_if.O_UPD_VLD && u_if.I_UPD_DONE;
        if (u_if.O_UPD_VLD) begin
          vld_cyc++;
          chk("calc_not_tile0", stat_cnt >= 2, 1'b1);
          if (stat_cnt >= 2 && stat_cnt <= 16) begin
            k = stat_cnt - 1;
            chk("li_old", u_if.O_LI_OLD, li_tab[k-1]);
            chk("mi_old", u_if.O_MI_OLD, mi_tab[k-1]);
            chk("li_new", u_if.O_LI_NEW, li_tab[k]);
            chk("mi_new", u_if.O_MI_NEW, mi_tab[k]);
          end
          chk("calc_idx", u_if.O_TILE_IDX, stat_cnt - 1);
          chk("calc_stat_rdy", u_if.O_STAT_RDY, 1'b0);
          last_mi_old = u_if.O_MI_OLD;
        end
        if (u_if.O_COEF_VLD) begin
          emit_cyc++;
          chk("coef_val", u_if.O_COEF, coef_exp);
          chk("emit_stat_rdy", u_if.O_STAT_RDY, 1'b0);
          chk("emit_idx", u_if.O_TILE_IDX, stat_cnt - 1);
          if (u_if.I_COEF_RDY) coef_cnt++;
        end
        if (u_if.O_DONE) begin
          done_cnt++;
          chk("done_after_stats", stat_cnt, (pass_n > 0) ? pass_n : 0);
          chk("done_after_coefs", coef_cnt, (pass_n > 0) ? pass_n - 1 : 0);
        end
        if (pass_n == 0) chk("zero_pass_busy", u_if.O_BUSY, 1'b0);
      end
    end
  end

  // Datapath model: returns a fresh random coefficient `lat` cycles into each request,
  // and throws spurious done pulses and junk coefficients at the controller otherwise.
  initial begin : datapath
    int cnt;
    mi_t c;
    cnt = 0;
    u_if.I_UPD_DONE = 1'b0;
    u_if.I_COEF     = '0;
    forever begin
      @(posedge clk);
      #1;
      if (u_if.O_UPD_VLD) begin
        cnt++;
        c = rnd_mi();
        u_if.I_COEF = c;
        if (cnt == lat) begin
          coef_exp        = c;
          u_if.I_UPD_DONE = 1'b1;
        end else begin
          u_if.I_UPD_DONE = 1'b0;
        end
      end else begin
        cnt             = 0;
        u_if.I_UPD_DONE = ($urandom % 4 == 0);
        u_if.I_COEF     = rnd_mi();
      end
    end
  end

  // Accumulator model: refuses the first stall_len offered cycles, then accepts randomly.
  initial begin : accum
    int ec;
    ec = 0;
    u_if.I_COEF_RDY = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (u_if.O_COEF_VLD) begin
        u_if.I_COEF_RDY = (ec >= stall_len) && ($urandom % 3 != 0);
        ec++;
      end else begin
        ec              = 0;
        u_if.I_COEF_RDY = ($urandom % 2 == 1);
      end
    end
  end

  // One cycle step; while busy, fire junk starts that must be ignored.
  task automatic tick();
    @(posedge clk);
    #1;
    if (u_if.O_BUSY) begin
      u_if.I_START    = ($urandom % 3 == 0);
      u_if.I_NUM_TILE = NT_W'($urandom);
    end else begin
      u_if.I_START = 1'b0;
    end
  endtask

  task automatic begin_pass(input int n, input int l, input int s);
    pass_n    = n;
    lat       = l;
    stall_len = s;
    stat_cnt  = 0; coef_cnt = 0; done_cnt = 0;
    vld_cyc   = 0; first_cnt = 0; emit_cyc = 0;
    for (int j = 0; j < n && j < 16; j++) begin
      li_tab[j] = rnd_li();
      mi_tab[j] = rnd_mi();
    end
    tick();
    u_if.I_START    = 1'b1;
    u_if.I_NUM_TILE = NT_W'(n);
    tick();
  endtask

  task automatic send_stat(input int j);
    logic hs;
    hs = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    u_if.I_STAT_VLD = 1'b1;
    u_if.I_LI_NEW   = li_tab[j];
    u_if.I_MI_NEW   = mi_tab[j];
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      hs = u_if.O_STAT_RDY;
      tick();
      if (hs) break;
    end
    chk("stat_handshake", hs, 1'b1);
    u_if.I_STAT_VLD = 1'b0;
    u_if.I_LI_NEW   = rnd_li();
    u_if.I_MI_NEW   = rnd_mi();
  endtask

  task automatic finish_pass(input int n);
    for (int t = 0; t < 4000 && done_cnt == 0; t++) tick();
    tick();
    tick();
    chk("done_once", done_cnt, 1);
    chk("stat_count", stat_cnt, n);
    chk("coef_handshakes", coef_cnt, (n > 0) ? n - 1 : 0);
    chk("upd_vld_cycles", vld_cyc, ((n > 0) ? n - 1 : 0) * lat);
    chk("first_once", first_cnt, (n > 0) ? 1 : 0);
    chk("idle_after_pass", u_if.O_BUSY, 1'b0);
  endtask

  task automatic run_pass(input int n, input int l, input int s);
    begin_pass(n, l, s);
    for (int j = 0; j < n; j++) send_stat(j);
    finish_pass(n);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_n           = 1'b0;
    u_if.I_START    = 1'b0;
    u_if.I_NUM_TILE = '0;
    u_if.I_STAT_VLD = 1'b0;
    u_if.I_LI_NEW   = '0;
    u_if.I_MI_NEW   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", u_if.O_BUSY, 1'b0);
    chk("rst_stat_rdy", u_if.O_STAT_RDY, 1'b0);
    chk("rst_done", u_if.O_DONE, 1'b0);
    chk("rst_idx", u_if.O_TILE_IDX, 0);
    chk("rst_coef", u_if.O_COEF, 0);
    chk("rst_li_old", u_if.O_LI_OLD, 0);
    #2 rst_n = 1'b1;

    // Single tile: seeds the stats, never visits the datapath.
    run_pass(1, 3, 0);
    chk("one_tile_no_upd", vld_cyc, 0);

    // Three tiles, 5-cycle datapath.
    run_pass(3, 5, 0);
    chk("three_tile_vld_cycles", vld_cyc, 10);
    chk("three_tile_coefs", coef_cnt, 2);
    chk("tile2_mi_old", last_mi_old, mi_tab[1]);

    // Accumulator holds off 10 cycles per coefficient.
    run_pass(2, 2, 10);
    chk("stall_emit_cycles", emit_cyc >= 11, 1'b1);

    // Empty pass: done one cycle after start, never busy.
    begin_pass(0, 1, 0);
    chk("zero_done_next", u_if.O_DONE, 1'b1);
    chk("zero_busy", u_if.O_BUSY, 1'b0);
    finish_pass(0);

    // Reset while tile 1 is in the datapath.
    begin_pass(3, 6, 0);
    send_stat(0);
    send_stat(1);
    for (int t = 0; t < 50 && !u_if.O_UPD_VLD; t++) tick();
    chk("reached_calc", u_if.O_UPD_VLD, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_upd", u_if.O_UPD_VLD, 1'b0);
    chk("mid_rst_busy", u_if.O_BUSY, 1'b0);
    chk("mid_rst_idx", u_if.O_TILE_IDX, 0);
    chk("mid_rst_mi_old", u_if.O_MI_OLD, 0);
    repeat (3) tick();
    #2 rst_n = 1'b1;
    repeat (6) tick();
    chk("abandon_no_done", done_cnt, 0);
    chk("abandon_idle", u_if.O_BUSY, 1'b0);
    run_pass(3, 5, 0);

    for (int p = 0; p < 20; p++) begin
      run_pass($urandom_range(0, 6), $urandom_range(1, 6), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
